// File: rtl/gemm_out_stream_writer_if.sv
// Result-beat stream and O-buffer write port bundled for gemm_out_stream_writer.
// master: producer/memory side; slave: the writer itself.
interface gemm_out_stream_writer_if;
  logic         in_valid;
  logic [1:0]   in_row;
  logic [2:0]   in_tile_in_head;
  logic [127:0] in_data;
  logic         O_mem_we;
  logic [6:0]   O_mem_addr;
  logic [127:0] O_mem_din;
  logic         O_mem_ready;

  modport master (
    output in_valid, in_row, in_tile_in_head, in_data, O_mem_ready,
    input  O_mem_we, O_mem_addr, O_mem_din
  );

  modport slave (
    input  in_valid, in_row, in_tile_in_head, in_data, O_mem_ready,
    output O_mem_we, O_mem_addr, O_mem_din
  );
endinterface

// File: rtl/gemm_out_stream_writer.sv
// Drains one head (32 beats) of GEMM results through a small FIFO into the O buffer.
// Optional beat-order checker enabled by defining GEMM_WR_ORDER_CHECK_EN.
module gemm_out_stream_writer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [6:0] O_BASE     = 7'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                head_sel,
  gemm_out_stream_writer_if.slave   bus,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      order_err
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 7 + 128;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [1:0]            head_r;
  logic [5:0]            beat_cnt_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  overflow_r;

  logic [ENTRY_W-1:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  beat_s;
  logic                  push_s;
  logic                  drop_s;
  logic [6:0]            beat_addr_s;

  assign empty_s     = (count_r == CNT_ZERO);
  assign full_s      = (count_r == CNT_FULL);
  assign pop_s       = !empty_s && bus.O_mem_ready;
  assign beat_s      = (state_r == ST_RUN) && bus.in_valid;
  // A pop in the same cycle frees a slot, so a beat arriving at full is still taken.
  assign push_s      = beat_s && (!full_s || pop_s);
  assign drop_s      = beat_s && full_s && !pop_s;
  assign beat_addr_s = O_BASE + {bus.in_row, head_r, bus.in_tile_in_head};

  assign bus.O_mem_we                   = !empty_s;
  assign {bus.O_mem_addr, bus.O_mem_din} = fifo_mem_r[rd_ptr_r];

  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = overflow_r;

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {ENTRY_W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {beat_addr_s, bus.in_data};
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Head sequencing FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      head_r     <= 2'd0;
      beat_cnt_r <= 6'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            head_r     <= head_sel;
            beat_cnt_r <= 6'd0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Dropped beats still count so a head always terminates.
          if (bus.in_valid) begin
            beat_cnt_r <= beat_cnt_r + 6'd1;
            if (beat_cnt_r == 6'd31) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (empty_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

`ifdef GEMM_WR_ORDER_CHECK_EN
  logic order_err_r;

  assign order_err = order_err_r;

  // Sticky check that beats arrive row-major with tile fastest.
  always_ff @(posedge clk) begin
    if (rst) begin
      order_err_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      order_err_r <= 1'b0;
    end else if (beat_s && ({bus.in_row, bus.in_tile_in_head} != beat_cnt_r[4:0])) begin
      order_err_r <= 1'b1;
    end else begin
      order_err_r <= order_err_r;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_gemm_out_stream_writer.sv
// Directed, table-driven bench for gemm_out_stream_writer (FIFO_DEPTH=4, O_BASE=0).
module tb_gemm_out_stream_writer;

  localparam logic [6:0] O_BASE_C = 7'd0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] head_sel;
  logic       busy, done, overflow, order_err;
  logic [1:0] cur_head;

  gemm_out_stream_writer_if bus_if ();

  gemm_out_stream_writer #(.FIFO_DEPTH(4), .O_BASE(O_BASE_C)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .head_sel  (head_sel),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0]   wr_addr_q [$];
  logic [127:0] wr_data_q [$];

  always @(posedge clk) begin
    if (!rst && bus_if.O_mem_we && bus_if.O_mem_ready) begin
      wr_addr_q.push_back(bus_if.O_mem_addr);
      wr_data_q.push_back(bus_if.O_mem_din);
    end
  end

  typedef struct {
    logic [1:0] head;
    logic [1:0] row;
    logic [2:0] tile;
    logic [6:0] exp_addr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_data(logic [1:0] h, logic [1:0] r, logic [2:0] t);
    logic [127:0] d;
    for (int l = 0; l < 4; l++) begin
      d[32*l +: 32] = {4'hC, 4'(l), 8'h5A, 9'd0, h, r, t};
    end
    return d;
  endfunction

  function automatic logic [6:0] exp_addr(logic [1:0] h, logic [1:0] r, logic [2:0] t);
    return O_BASE_C + {r, h, t};
  endfunction

  function automatic logic [128:0] find_wr(int base, logic [6:0] a);
    logic [128:0] res;
    res = {1'b0, 128'd0};
    for (int k = base; k < wr_addr_q.size(); k++) begin
      if (wr_addr_q[k] == a) res = {1'b1, wr_data_q[k]};
    end
    return res;
  endfunction

  task automatic send_beat(logic [1:0] r, logic [2:0] t);
    bus_if.in_valid        = 1'b1;
    bus_if.in_row          = r;
    bus_if.in_tile_in_head = t;
    bus_if.in_data         = mk_data(cur_head, r, t);
    tick();
    bus_if.in_valid        = 1'b0;
  endtask

  task automatic send_range(int lo, int hi, int gap);
    for (int b = lo; b <= hi; b++) begin
      logic [4:0] bb;
      bb = 5'(b);
      send_beat(bb[4:3], bb[2:0]);
      for (int g = 1; g < gap; g++) tick();
    end
  endtask

  task automatic do_start(logic [1:0] h);
    cur_head = h;
    head_sel = h;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      seen = done;
    end
    chk1(name, seen, 1'b1);
    tick();
    chk1("done_one_cycle", done, 1'b0);
  endtask

  // Writes from base must be beats lo..hi of cur_head, in order.
  task automatic chk_seq(string name, int base, int lo, int hi);
    logic ok;
    ok = (wr_addr_q.size() >= base + hi - lo + 1);
    for (int k = lo; k <= hi && ok; k++) begin
      logic [4:0] bb;
      bb = 5'(k);
      if (wr_addr_q[base + k - lo] !== exp_addr(cur_head, bb[4:3], bb[2:0]) ||
          wr_data_q[base + k - lo] !== mk_data(cur_head, bb[4:3], bb[2:0])) ok = 1'b0;
    end
    chk1(name, ok, 1'b1);
  endtask

  task automatic run_head(logic [1:0] h, int gap);
    int base;
    base = wr_addr_q.size();
    do_start(h);
    send_range(0, 30, gap);
    send_beat(2'd3, 3'd7);
    tick();
    chk1("done_n2", done, 1'b0);
    tick();
    chk1("done_n3", done, 1'b1);
    chk1("busy_at_done", busy, 1'b0);
    tick();
    chk1("done_pulse", done, 1'b0);
    chk_i("wr_count", wr_addr_q.size() - base, 32);
    chk_seq("wr_seq", base, 0, 31);
    chk1("overflow_nom", overflow, 1'b0);
    chk1("order_err_nom", order_err, 1'b0);
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].head == h) begin
        logic [128:0] f;
        f = find_wr(base, vecs[v].exp_addr);
        chk1("vec_addr_hit", f[128], 1'b1);
        chk("vec_data", f[127:0], mk_data(h, vecs[v].row, vecs[v].tile));
      end
    end
  endtask

  initial begin
    logic [1:0]   heads [4];
    int           gaps  [4];
    int           base;
    logic         exp_oe;
    logic [128:0] f;

    vecs[0] = '{head: 2'd2, row: 2'd1, tile: 3'd5, exp_addr: 7'h35};
    vecs[1] = '{head: 2'd2, row: 2'd0, tile: 3'd0, exp_addr: 7'h10};
    vecs[2] = '{head: 2'd2, row: 2'd3, tile: 3'd7, exp_addr: 7'h77};
    vecs[3] = '{head: 2'd0, row: 2'd0, tile: 3'd0, exp_addr: 7'h00};
    vecs[4] = '{head: 2'd0, row: 2'd2, tile: 3'd3, exp_addr: 7'h43};
    vecs[5] = '{head: 2'd3, row: 2'd3, tile: 3'd7, exp_addr: 7'h7F};
    vecs[6] = '{head: 2'd1, row: 2'd1, tile: 3'd2, exp_addr: 7'h2A};
    heads = '{2'd2, 2'd0, 2'd3, 2'd1};
    gaps  = '{20, 1, 1, 1};

    rst                    = 1'b1;
    start                  = 1'b0;
    head_sel               = 2'd0;
    cur_head               = 2'd0;
    bus_if.in_valid        = 1'b0;
    bus_if.in_row          = 2'd0;
    bus_if.in_tile_in_head = 3'd0;
    bus_if.in_data         = 128'd0;
    bus_if.O_mem_ready     = 1'b1;
    repeat (3) tick();
    chk1("rst_we", bus_if.O_mem_we, 1'b0);
    chk("rst_addr", 128'(bus_if.O_mem_addr), 128'd0);
    chk("rst_din", bus_if.O_mem_din, 128'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_order_err", order_err, 1'b0);
    rst = 1'b0;
    tick();

    send_beat(2'd0, 3'd0);
    tick();
    chk1("idle_beat_ignored", bus_if.O_mem_we, 1'b0);

    for (int i = 0; i < 4; i++) run_head(heads[i], gaps[i]);

    // Back-pressure: two beats 10 apart while the port stalls for 40 cycles.
    base = wr_addr_q.size();
    bus_if.O_mem_ready = 1'b0;
    do_start(2'd1);
    send_beat(2'd0, 3'd0);
    chk1("bp_we", bus_if.O_mem_we, 1'b1);
    chk("bp_addr0", 128'(bus_if.O_mem_addr), 128'(7'h08));
    chk("bp_din0", bus_if.O_mem_din, mk_data(2'd1, 2'd0, 3'd0));
    repeat (9) tick();
    send_beat(2'd0, 3'd1);
    repeat (29) tick();
    chk("bp_addr_hold", 128'(bus_if.O_mem_addr), 128'(7'h08));
    chk("bp_din_hold", bus_if.O_mem_din, mk_data(2'd1, 2'd0, 3'd0));
    chk_i("bp_no_writes", wr_addr_q.size() - base, 0);
    bus_if.O_mem_ready = 1'b1;
    send_range(2, 31, 1);
    wait_done("bp_done");
    chk_i("bp_wr_count", wr_addr_q.size() - base, 32);
    chk_seq("bp_seq", base, 0, 31);
    chk1("bp_overflow", overflow, 1'b0);

    // Overflow: port stalled for the whole head, only the first 4 beats survive.
    base = wr_addr_q.size();
    bus_if.O_mem_ready = 1'b0;
    do_start(2'd3);
    send_range(0, 3, 1);
    chk1("ovf_not_yet", overflow, 1'b0);
    send_beat(2'd0, 3'd4);
    chk1("ovf_set", overflow, 1'b1);
    send_range(5, 31, 1);
    bus_if.O_mem_ready = 1'b1;
    wait_done("ovf_done");
    chk1("ovf_sticky", overflow, 1'b1);
    chk_i("ovf_wr_count", wr_addr_q.size() - base, 4);
    chk_seq("ovf_seq", base, 0, 3);

    // Full FIFO with a pop in the same cycle as a new beat.
    base = wr_addr_q.size();
    bus_if.O_mem_ready = 1'b0;
    do_start(2'd2);
    chk1("full_ovf_cleared", overflow, 1'b0);
    send_range(0, 3, 1);
    bus_if.O_mem_ready = 1'b1;
    send_beat(2'd0, 3'd4);
    chk1("full_pop_no_ovf", overflow, 1'b0);
    send_range(5, 31, 1);
    wait_done("full_done");
    chk_i("full_wr_count", wr_addr_q.size() - base, 32);
    chk_seq("full_seq", base, 0, 31);
    chk1("full_overflow", overflow, 1'b0);

    // Out-of-order beats: tiles 3 and 4 of row 0 swapped.
`ifdef GEMM_WR_ORDER_CHECK_EN
    exp_oe = 1'b1;
`else
    exp_oe = 1'b0;
`endif
    base = wr_addr_q.size();
    do_start(2'd1);
    send_beat(2'd0, 3'd0);
    send_beat(2'd0, 3'd1);
    send_beat(2'd0, 3'd2);
    send_beat(2'd0, 3'd4);
    send_beat(2'd0, 3'd3);
    send_range(5, 31, 1);
    wait_done("ord_done");
    chk1("ord_order_err", order_err, exp_oe);
    chk_i("ord_wr_count", wr_addr_q.size() - base, 32);
    f = find_wr(base, 7'h0B);
    chk1("ord_t3_hit", f[128], 1'b1);
    chk("ord_t3_data", f[127:0], mk_data(2'd1, 2'd0, 3'd3));
    f = find_wr(base, 7'h0C);
    chk1("ord_t4_hit", f[128], 1'b1);
    chk("ord_t4_data", f[127:0], mk_data(2'd1, 2'd0, 3'd4));

    // Reset mid-run with three beats queued.
    do_start(2'd0);
    send_range(0, 7, 1);
    bus_if.O_mem_ready = 1'b0;
    send_range(8, 9, 1);
    chk1("mid_we_queued", bus_if.O_mem_we, 1'b1);
    rst = 1'b1;
    tick();
    chk1("mid_rst_we", bus_if.O_mem_we, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", 128'(bus_if.O_mem_addr), 128'd0);
    chk("mid_rst_din", bus_if.O_mem_din, 128'd0);
    rst = 1'b0;
    bus_if.O_mem_ready = 1'b1;
    tick();
    run_head(2'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
